// File: rtl/dmem_requester_if.sv
// Handshake bundles for the data-memory requester: pipeline request/response side
// and the memory strobe/data side.
interface dmem_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface dmem_bus_if;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        memread;
   logic        memwrite;
   logic [3:0]  sign_mask;
   logic [31:0] read_data;
   logic        clk_stall;

   modport master (
      output addr, write_data, memread, memwrite, sign_mask,
      input  read_data, clk_stall
   );
   modport slave (
      input  addr, write_data, memread, memwrite, sign_mask,
      output read_data, clk_stall
   );
endinterface

// File: rtl/dmem_requester.sv
// One-at-a-time load/store initiator: decodes funct3 into sign_mask, rejects illegal or
// misaligned accesses, issues single-cycle strobes and returns a one-cycle response.
module dmem_requester #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   dmem_req_if.slave  req,
   dmem_bus_if.master mem
);

   typedef enum logic [2:0] {IDLE, ISSUE, RD_DATA, WR_WAIT, RESP} state_e;

   localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [3:0]  mask_q, mask_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        resp_valid_q, resp_valid_d;
   logic        memread_q, memread_d;
   logic        memwrite_q, memwrite_d;
   logic        seen_q, seen_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [3:0]  dec_mask;
   logic        dec_legal;
   logic        dec_misalign;
   logic        dec_bad;
   logic        wr_done;

   always_comb begin
      dec_mask  = '0;
      dec_legal = 1'b0;
      case (req.req_funct3)
         3'b000: begin dec_mask = req.req_we ? 4'b0001 : 4'b1001; dec_legal = 1'b1; end
         3'b001: begin dec_mask = req.req_we ? 4'b0011 : 4'b1011; dec_legal = 1'b1; end
         3'b010: begin dec_mask = 4'b0111; dec_legal = 1'b1; end
         3'b100: begin dec_mask = 4'b0001; dec_legal = !req.req_we; end
         3'b101: begin dec_mask = 4'b0011; dec_legal = !req.req_we; end
         default: ;
      endcase
      dec_misalign = ((dec_mask[2:1] == 2'b01) && req.req_addr[0]) ||
                     (dec_mask[2] && (req.req_addr[1:0] != 2'b00));
      dec_bad      = !dec_legal || dec_misalign;
   end

   // A stall already seen followed by a low clk_stall means the write has landed.
   assign wr_done = seen_q && !mem.clk_stall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         mask_q       <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         memread_q    <= 1'b0;
         memwrite_q   <= 1'b0;
         seen_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         mask_q       <= mask_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         resp_valid_q <= resp_valid_d;
         memread_q    <= memread_d;
         memwrite_q   <= memwrite_d;
         seen_q       <= seen_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req.req_valid) state_d = dec_bad ? RESP : ISSUE;
         ISSUE:   state_d = we_q ? WR_WAIT : RD_DATA;
         RD_DATA: state_d = RESP;
         WR_WAIT: if (wr_done || (cnt_q == CNT_LAST)) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered, so strobes and response are computed for the state being entered.
   always_comb begin
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      mask_d       = mask_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      seen_d       = seen_q;
      cnt_d        = cnt_q;
      resp_valid_d = 1'b0;
      memread_d    = 1'b0;
      memwrite_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req.req_valid) begin
               addr_d  = req.req_addr;
               wdata_d = req.req_wdata;
               we_d    = req.req_we;
               mask_d  = dec_mask;
               if (dec_bad) begin
                  err_d        = 1'b1;
                  resp_valid_d = 1'b1;
               end else begin
                  memread_d  = !req.req_we;
                  memwrite_d = req.req_we;
               end
            end
         end
         RD_DATA: begin
            rdata_d      = mem.read_data;
            resp_valid_d = 1'b1;
         end
         WR_WAIT: begin
            if (mem.clk_stall) seen_d = 1'b1;
            cnt_d = cnt_q + 4'd1;
            if (state_d == RESP) begin
               resp_valid_d = 1'b1;
               err_d        = !wr_done;
            end
         end
         RESP: begin
            rdata_d = '0;
            err_d   = 1'b0;
            seen_d  = 1'b0;
            cnt_d   = '0;
         end
         default: ;
      endcase
   end

   assign req.req_ready  = (state_q == IDLE);
   assign req.resp_valid = resp_valid_q;
   assign req.resp_rdata = rdata_q;
   assign req.resp_err   = err_q;
   assign mem.addr       = addr_q;
   assign mem.write_data = wdata_q;
   assign mem.memread    = memread_q;
   assign mem.memwrite   = memwrite_q;
   assign mem.sign_mask  = mask_q;

endmodule

// File: tb/tb_dmem_requester.sv
// Randomized and directed bench for dmem_requester against a byte-array memory and
// a funct3-level reference model.
module tb_dmem_requester;
   localparam int unsigned TIMEOUT = 15;

   logic clk = 1'b0;
   logic reset_n;

   dmem_req_if req_if ();
   dmem_bus_if bus_if ();

   dmem_requester #(.TIMEOUT(TIMEOUT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_if),
      .mem     (bus_if)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory model: registered read data, byte lanes selected by sign_mask,
   // clk_stall held high for stall_cfg cycles after each write.
   bit   [7:0]  mem [256];
   int unsigned stall_cfg  = 0;
   int unsigned stall_left = 0;
   logic [31:0] rd_q = '0;

   assign bus_if.read_data = rd_q;
   assign bus_if.clk_stall = (stall_left != 0);

   function automatic logic [31:0] mem_fetch(input logic [3:0] m, input logic [7:0] a);
      logic [7:0] b0, b1, b2, b3;
      b0 = mem[a];
      b1 = mem[8'(a + 8'd1)];
      b2 = mem[8'(a + 8'd2)];
      b3 = mem[8'(a + 8'd3)];
      if (m[2]) return {b3, b2, b1, b0};
      if (m[1]) return m[3] ? {{16{b1[7]}}, b1, b0} : {16'h0000, b1, b0};
      return m[3] ? {{24{b0[7]}}, b0} : {24'h000000, b0};
   endfunction

   always @(posedge clk) begin
      if (bus_if.memread) rd_q <= mem_fetch(bus_if.sign_mask, bus_if.addr[7:0]);
      if (bus_if.memwrite) begin
         mem[bus_if.addr[7:0]] <= bus_if.write_data[7:0];
         if (bus_if.sign_mask[1]) mem[8'(bus_if.addr[7:0] + 8'd1)] <= bus_if.write_data[15:8];
         if (bus_if.sign_mask[2]) begin
            mem[8'(bus_if.addr[7:0] + 8'd2)] <= bus_if.write_data[23:16];
            mem[8'(bus_if.addr[7:0] + 8'd3)] <= bus_if.write_data[31:24];
         end
         stall_left <= stall_cfg;
      end else if (stall_left != 0) begin
         stall_left <= stall_left - 1;
      end
   end

   // Reference model, expressed directly in RV32I terms.
   bit [7:0] ref_mem [256];

   function automatic bit ref_legal(input logic we, input logic [2:0] f3);
      if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic logic [3:0] ref_mask(input logic we, input logic [2:0] f3);
      if (we) begin
         case (f3)
            3'd0: return 4'b0001;
            3'd1: return 4'b0011;
            default: return 4'b0111;
         endcase
      end
      case (f3)
         3'd0: return 4'b1001;
         3'd4: return 4'b0001;
         3'd1: return 4'b1011;
         3'd5: return 4'b0011;
         default: return 4'b0111;
      endcase
   endfunction

   function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
      if (f3[1:0] == 2'd1) return a[0];
      if (f3[1:0] == 2'd2) return a[1:0] != 2'd0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      int unsigned i;
      logic [31:0] w;
      i = a[7:0];
      w = {ref_mem[(i + 3) % 256], ref_mem[(i + 2) % 256], ref_mem[(i + 1) % 256], ref_mem[i]};
      case (f3)
         3'd0: return 32'($signed(w[7:0]));
         3'd4: return 32'(w[7:0]);
         3'd1: return 32'($signed(w[15:0]));
         3'd5: return 32'(w[15:0]);
         default: return w;
      endcase
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int unsigned nbytes;
      nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      for (int unsigned k = 0; k < nbytes; k++)
         ref_mem[(int'(a[7:0]) + k) % 256] = wd[8*k +: 8];
   endtask

   task automatic check_mem(input string tag);
      int unsigned diffs;
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] != ref_mem[i]) diffs++;
      chk(tag, diffs, 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " req_ready"},  32'(req_if.req_ready), 32'd1);
      chk({tag, " resp_valid"}, 32'(req_if.resp_valid), 32'd0);
      chk({tag, " resp_err"},   32'(req_if.resp_err), 32'd0);
      chk({tag, " resp_rdata"}, req_if.resp_rdata, 32'd0);
      chk({tag, " memread"},    32'(bus_if.memread), 32'd0);
      chk({tag, " memwrite"},   32'(bus_if.memwrite), 32'd0);
      chk({tag, " addr"},       bus_if.addr, 32'd0);
      chk({tag, " write_data"}, bus_if.write_data, 32'd0);
      chk({tag, " sign_mask"},  32'(bus_if.sign_mask), 32'd0);
   endtask

   // Call at posedge+1; returns at posedge+1 one cycle after the response pulse.
   task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int unsigned stall);
      bit          bad;
      int unsigned exp_lat, lat, rd_n, wr_n;
      logic        exp_err, g_err, got_resp;
      logic [31:0] exp_rd, g_rd, s_addr, s_wdata;
      logic [3:0]  s_mask;
      bad = !ref_legal(we, f3) || ref_misaligned(f3, a);
      exp_rd = '0;
      if (bad) begin
         exp_lat = 0; exp_err = 1'b1;
      end else if (!we) begin
         exp_lat = 2; exp_err = 1'b0; exp_rd = ref_load(f3, a);
      end else if (stall != 0 && stall + 2 <= TIMEOUT + 1) begin
         exp_lat = stall + 2; exp_err = 1'b0;
      end else begin
         exp_lat = TIMEOUT + 1; exp_err = 1'b1;
      end
      stall_cfg         = stall;
      req_if.req_we     = we;
      req_if.req_funct3 = f3;
      req_if.req_addr   = a;
      req_if.req_wdata  = wd;
      req_if.req_valid  = 1'b1;
      for (int i = 0; i < 40 && req_if.req_ready !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      chk({name, " ready"}, 32'(req_if.req_ready), 32'd1);
      @(posedge clk); #1;
      req_if.req_valid = 1'b0;
      chk({name, " busy"}, 32'(req_if.req_ready), 32'd0);
      got_resp = 1'b0; lat = 0; rd_n = 0; wr_n = 0;
      g_rd = '0; g_err = 1'b0; s_addr = '0; s_wdata = '0; s_mask = '0;
      for (int n = 0; n < 40; n++) begin
         if (bus_if.memread === 1'b1) begin
            rd_n++; s_mask = bus_if.sign_mask; s_addr = bus_if.addr;
         end
         if (bus_if.memwrite === 1'b1) begin
            wr_n++; s_mask = bus_if.sign_mask; s_addr = bus_if.addr; s_wdata = bus_if.write_data;
         end
         if (req_if.resp_valid === 1'b1) begin
            got_resp = 1'b1; lat = n; g_rd = req_if.resp_rdata; g_err = req_if.resp_err;
            break;
         end
         @(posedge clk); #1;
      end
      chk({name, " resp_seen"}, 32'(got_resp), 32'd1);
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " err"}, 32'(g_err), 32'(exp_err));
      chk({name, " rdata"}, g_rd, exp_rd);
      chk({name, " memread_cycles"}, rd_n, (!bad && !we) ? 32'd1 : 32'd0);
      chk({name, " memwrite_cycles"}, wr_n, (!bad && we) ? 32'd1 : 32'd0);
      if (!bad) begin
         chk({name, " sign_mask"}, 32'(s_mask), 32'(ref_mask(we, f3)));
         chk({name, " addr"}, s_addr, a);
      end
      if (!bad && we) chk({name, " write_data"}, s_wdata, wd);
      @(posedge clk); #1;
      chk({name, " pulse_end"}, 32'(req_if.resp_valid), 32'd0);
      chk({name, " idle_ready"}, 32'(req_if.req_ready), 32'd1);
      if (!bad && we) ref_store(f3, a, wd);
   endtask

   initial begin
      int unsigned pulses;
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] ra;
      int unsigned rst;

      req_if.req_valid  = 1'b0;
      req_if.req_we     = 1'b0;
      req_if.req_funct3 = '0;
      req_if.req_addr   = '0;
      req_if.req_wdata  = '0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1 check_reset_vals("reset");
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      do_req("sw_deadbeef", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1);
      do_req("lw_10",       1'b0, 3'd2, 32'h10, 32'h0, 0);
      do_req("sw_80ff",     1'b1, 3'd2, 32'h20, 32'h000080FF, 1);
      do_req("lb_20",       1'b0, 3'd0, 32'h20, 32'h0, 0);
      do_req("lbu_20",      1'b0, 3'd4, 32'h20, 32'h0, 0);
      do_req("lh_20",       1'b0, 3'd1, 32'h20, 32'h0, 0);
      do_req("lhu_20",      1'b0, 3'd5, 32'h20, 32'h0, 0);
      do_req("lh_21_mis",   1'b0, 3'd1, 32'h21, 32'h0, 0);
      do_req("sw_22_mis",   1'b1, 3'd2, 32'h22, 32'h12345678, 1);
      check_mem("mem_after_misaligned");
      do_req("ld_f3_011",   1'b0, 3'd3, 32'h20, 32'h0, 0);
      do_req("st_f3_100",   1'b1, 3'd4, 32'h24, 32'hA5A5A5A5, 1);
      do_req("sb_stall3",   1'b1, 3'd0, 32'h33, 32'h000000C3, 3);
      do_req("sh_stall5",   1'b1, 3'd1, 32'h36, 32'h0000BEEF, 5);
      do_req("sw_timeout",  1'b1, 3'd2, 32'h30, 32'h01020304, 0);
      do_req("lw_30",       1'b0, 3'd2, 32'h30, 32'h0, 0);

      // Reset while parked in WR_WAIT with the memory never stalling.
      stall_cfg         = 0;
      req_if.req_we     = 1'b1;
      req_if.req_funct3 = 3'd2;
      req_if.req_addr   = 32'h40;
      req_if.req_wdata  = 32'hCAFEF00D;
      req_if.req_valid  = 1'b1;
      @(posedge clk); #1;
      req_if.req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_vals("mid_reset");
      pulses = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (req_if.resp_valid !== 1'b0) pulses++;
      end
      chk("mid_reset no_resp", pulses, 32'd0);
      ref_store(3'd2, 32'h40, 32'hCAFEF00D);
      @(negedge clk) reset_n = 1'b1;
      #1 chk("post_reset ready", 32'(req_if.req_ready), 32'd1);
      @(posedge clk); #1;
      do_req("lw_after_reset", 1'b0, 3'd2, 32'h40, 32'h0, 0);

      for (int t = 0; t < 60; t++) begin
         rwe = 1'($urandom_range(0, 1));
         rf3 = 3'($urandom_range(0, 7));
         ra  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         rst = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
         do_req("rnd", rwe, rf3, ra, $urandom, rst);
      end
      check_mem("mem_final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
